// File: rtl/irq_pending_collector.sv
// rtl/irq_pending_collector.sv - sticky request capture, masked lowest-index pick, offer/service handshake
module irq_pending_collector #(
  parameter int N    = 16,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    mask_i,
  input  logic            vec_ready,
  input  logic            eoi_i,
  input  logic            ovf_clr_i,
  output logic [N-1:0]    pend_o,
  output logic            vec_valid,
  output logic [IDXW-1:0] vec_idx,
  output logic            busy_o,
  output logic [N-1:0]    ovf_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OFFER   = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    pend_q, pend_d;
  logic [N-1:0]    ovf_q, ovf_d;
  logic            vec_valid_q, vec_valid_d;
  logic [IDXW-1:0] vec_idx_q, vec_idx_d;
  logic [N-1:0]    clr;
  logic [IDXW-1:0] sel;
  logic            any;
  logic            accept;

  assign pend_o    = pend_q & mask_i;
  assign any       = |pend_o;
  assign vec_valid = vec_valid_q;
  assign vec_idx   = vec_idx_q;
  assign busy_o    = (state_q == ST_SERVICE);
  assign ovf_o     = ovf_q;
  assign accept    = vec_valid_q & vec_ready;

  // Descending scan so the last assignment is the lowest set index.
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_o[i]) sel = IDXW'(i);
    end
  end

  always_comb begin
    clr = '0;
    if (accept) clr[vec_idx_q] = 1'b1;
  end

  // A request arriving on the clearing edge re-arms the bit and is not a loss.
  always_comb begin
    pend_d = (pend_q & ~clr) | req_i;
    ovf_d  = (ovf_q & ~{N{ovf_clr_i}}) | (req_i & pend_q & ~clr);
  end

  always_comb begin
    state_d     = state_q;
    vec_valid_d = vec_valid_q;
    vec_idx_d   = vec_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          vec_idx_d   = sel;
          vec_valid_d = 1'b1;
          state_d     = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (accept) begin
          vec_valid_d = 1'b0;
          state_d     = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi_i) state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        vec_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      ovf_q       <= '0;
      vec_valid_q <= 1'b0;
      vec_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      vec_valid_q <= vec_valid_d;
      vec_idx_q   <= vec_idx_d;
    end
  end

endmodule

// File: tb/tb_irq_pending_collector.sv
// tb/tb_irq_pending_collector.sv - directed self-checking bench for irq_pending_collector
module tb_irq_pending_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req_i, mask_i;
  logic        vec_ready, eoi_i, ovf_clr_i;
  logic [15:0] pend_o, ovf_o;
  logic        vec_valid, busy_o;
  logic [3:0]  vec_idx;

  int checks = 0;
  int errors = 0;

  irq_pending_collector #(.N(16), .IDXW(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .mask_i(mask_i),
    .vec_ready(vec_ready), .eoi_i(eoi_i), .ovf_clr_i(ovf_clr_i),
    .pend_o(pend_o), .vec_valid(vec_valid), .vec_idx(vec_idx),
    .busy_o(busy_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic eoi_pulse();
    eoi_i = 1'b1;
    tick();
    eoi_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_i = 16'hFFFF; mask_i = 16'hFFFF;
    vec_ready = 1'b0; eoi_i = 1'b0; ovf_clr_i = 1'b0;
    repeat (3) tick();

    // 1 reset
    chk("rst_valid", 32'(vec_valid), 32'd0);
    chk("rst_idx",   32'(vec_idx),   32'd0);
    chk("rst_busy",  32'(busy_o),    32'd0);
    chk("rst_ovf",   32'(ovf_o),     32'h0);
    chk("rst_pend",  32'(pend_o),    32'h0);
    rst_n = 1'b1; req_i = 16'h0;
    tick();

    // 2 priority
    req_i = 16'h8004; vec_ready = 1'b1;
    tick();
    req_i = 16'h0;
    chk("pri_c1_valid", 32'(vec_valid), 32'd0);
    chk("pri_c1_pend",  32'(pend_o),    32'h8004);
    tick();
    chk("pri_c2_valid", 32'(vec_valid), 32'd1);
    chk("pri_c2_idx",   32'(vec_idx),   32'd2);
    tick();
    chk("pri_acc_valid", 32'(vec_valid), 32'd0);
    chk("pri_acc_busy",  32'(busy_o),    32'd1);
    chk("pri_acc_pend",  32'(pend_o),    32'h8000);
    eoi_pulse();
    chk("pri_idle_valid", 32'(vec_valid), 32'd0);
    tick();
    chk("pri_15_valid", 32'(vec_valid), 32'd1);
    chk("pri_15_idx",   32'(vec_idx),   32'd15);
    tick();
    chk("pri_15_busy", 32'(busy_o), 32'd1);
    chk("pri_15_pend", 32'(pend_o), 32'h0);
    eoi_pulse();
    tick();
    chk("pri_end_valid", 32'(vec_valid), 32'd0);
    chk("pri_end_busy",  32'(busy_o),    32'd0);
    chk("pri_end_pend",  32'(pend_o),    32'h0);

    // 3 backpressure
    vec_ready = 1'b0;
    req_i = 16'h0004;
    tick();
    req_i = 16'h0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid_%0d", k), 32'(vec_valid), 32'd1);
      chk($sformatf("bp_idx_%0d", k),   32'(vec_idx),   32'd2);
      req_i = (k == 2) ? 16'h0001 : 16'h0;
      tick();
    end
    req_i = 16'h0;
    chk("bp_hold_idx", 32'(vec_idx), 32'd2);
    vec_ready = 1'b1;
    tick();
    chk("bp_acc_busy", 32'(busy_o), 32'd1);
    chk("bp_acc_pend", 32'(pend_o), 32'h0001);
    eoi_pulse();
    tick();
    chk("bp_idx0_valid", 32'(vec_valid), 32'd1);
    chk("bp_idx0_idx",   32'(vec_idx),   32'd0);
    tick();
    eoi_pulse();
    tick();

    // 4 mask
    mask_i = 16'hFFFB; vec_ready = 1'b0;
    req_i = 16'h0004;
    tick();
    req_i = 16'h0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("mask_valid_%0d", k), 32'(vec_valid), 32'd0);
      chk($sformatf("mask_pend_%0d", k),  32'(pend_o),    32'h0);
      tick();
    end
    mask_i = 16'hFFFF;
    tick();
    chk("mask_on_valid1", 32'(vec_valid), 32'd1);
    tick();
    chk("mask_on_valid2", 32'(vec_valid), 32'd1);
    chk("mask_on_idx",    32'(vec_idx),   32'd2);
    vec_ready = 1'b1;
    tick();
    eoi_pulse();
    tick();

    // 5a overflow
    vec_ready = 1'b0;
    req_i = 16'h0020;
    tick();
    req_i = 16'h0;
    tick();
    chk("ovf_none", 32'(ovf_o), 32'h0);
    req_i = 16'h0020;
    tick();
    req_i = 16'h0;
    chk("ovf_set", 32'(ovf_o), 32'h0020);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    chk("ovf_clr", 32'(ovf_o), 32'h0);
    vec_ready = 1'b1;
    tick();
    chk("ovf_acc_pend", 32'(pend_o), 32'h0);
    eoi_pulse();
    tick();

    // 5b set/clear collision
    vec_ready = 1'b0;
    req_i = 16'h0004;
    tick();
    req_i = 16'h0;
    tick();
    chk("col_idx", 32'(vec_idx), 32'd2);
    vec_ready = 1'b1; req_i = 16'h0004;
    tick();
    req_i = 16'h0; vec_ready = 1'b0;
    chk("col_busy", 32'(busy_o), 32'd1);
    chk("col_ovf",  32'(ovf_o),  32'h0);
    chk("col_pend", 32'(pend_o), 32'h0004);
    eoi_pulse();
    tick();
    chk("col_re_valid", 32'(vec_valid), 32'd1);
    chk("col_re_idx",   32'(vec_idx),   32'd2);
    vec_ready = 1'b1;
    tick();
    eoi_pulse();
    tick();

    // 6 reset mid-service
    req_i = 16'h0008;
    tick();
    req_i = 16'h0;
    tick();
    tick();
    chk("rs_busy", 32'(busy_o), 32'd1);
    req_i = 16'h0010;
    tick();
    req_i = 16'h0;
    chk("rs_pend_before", 32'(pend_o), 32'h0010);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rs_busy0",  32'(busy_o),    32'd0);
    chk("rs_pend0",  32'(pend_o),    32'h0);
    chk("rs_valid0", 32'(vec_valid), 32'd0);
    eoi_pulse();
    tick();
    chk("rs_eoi_busy",  32'(busy_o),    32'd0);
    chk("rs_eoi_valid", 32'(vec_valid), 32'd0);
    chk("rs_eoi_pend",  32'(pend_o),    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
